// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of in-flight branch predictions that owns the speculative GHR
// and emits registered training packets at resolution. Optional macro: BRQ_HIST_REPAIR_EN.
module branch_resolve_queue #(
    parameter int HIST_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pred_valid,
    output logic                       pred_ready,
    input  logic                       lp_prediction,
    input  logic                       gp_prediction,
    input  logic                       choice_prediction,
    output logic [HIST_W-1:0]          global_history,
    input  logic                       resolve_valid,
    input  logic                       actually_taken,
    output logic                       upd_valid,
    output logic [HIST_W-1:0]          upd_index,
    output logic                       upd_count_up,
    output logic                       upd_count_down,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       err_underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [HIST_W-1:0] hist;
        logic              lp;
        logic              gp;
        logic              fin;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    entry_t           head_e;
    logic             final_pred;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             head_mis;
    logic             recover;

    // NOTE: every signal is assigned unconditionally in this always_comb, so no latch can be inferred.
    always_comb begin
        final_pred = choice_prediction ? gp_prediction : lp_prediction;
        pred_ready = (occupancy != OCC_W'(DEPTH));
        push_req   = pred_valid && pred_ready;
        pop        = resolve_valid && (occupancy != '0);
        head_e     = mem[head_ptr];
        head_mis   = pop && (head_e.fin != actually_taken);
`ifdef BRQ_HIST_REPAIR_EN
        recover    = head_mis;
`else
        recover    = 1'b0;
`endif
        // A recovering resolve squashes any push arriving in the same cycle.
        push       = push_req && !recover;
    end

    // NOTE: the entry array is deliberately not reset; pointers and occupancy alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail_ptr] <= '{hist: global_history, lp: lp_prediction, gp: gp_prediction, fin: final_pred};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_ptr       <= '0;
            tail_ptr       <= '0;
            occupancy      <= '0;
            global_history <= '0;
            err_underflow  <= 1'b0;
        end else begin
            if (resolve_valid && (occupancy == '0)) begin
                err_underflow <= 1'b1;
            end
            if (recover) begin
                // Rebuild history from the resolved branch's own index plus its true outcome.
                global_history <= {head_e.hist[HIST_W-2:0], actually_taken};
                head_ptr       <= head_ptr + PTR_W'(1);
                tail_ptr       <= head_ptr + PTR_W'(1);
                occupancy      <= '0;
            end else begin
                if (push) begin
                    global_history <= {global_history[HIST_W-2:0], final_pred};
                    tail_ptr       <= tail_ptr + PTR_W'(1);
                end
                if (pop) begin
                    head_ptr <= head_ptr + PTR_W'(1);
                end
                occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            upd_valid      <= 1'b0;
            upd_index      <= '0;
            upd_count_up   <= 1'b0;
            upd_count_down <= 1'b0;
            upd_taken      <= 1'b0;
            mispredict     <= 1'b0;
        end else begin
            upd_valid  <= pop;
            mispredict <= head_mis;
            if (pop) begin
                upd_index      <= head_e.hist;
                upd_count_up   <= (actually_taken == head_e.gp) && (actually_taken != head_e.lp);
                upd_count_down <= (actually_taken == head_e.lp) && (actually_taken != head_e.gp);
                upd_taken      <= actually_taken;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_branch_resolve_queue;
    localparam int HIST_W = 12;
    localparam int DEPTH  = 8;
    localparam int OCC_W  = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              pred_valid = 1'b0;
    logic              pred_ready;
    logic              lp_prediction = 1'b0;
    logic              gp_prediction = 1'b0;
    logic              choice_prediction = 1'b0;
    logic [HIST_W-1:0] global_history;
    logic              resolve_valid = 1'b0;
    logic              actually_taken = 1'b0;
    logic              upd_valid;
    logic [HIST_W-1:0] upd_index;
    logic              upd_count_up;
    logic              upd_count_down;
    logic              upd_taken;
    logic              mispredict;
    logic [OCC_W-1:0]  occupancy;
    logic              err_underflow;

    branch_resolve_queue #(.HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .pred_valid(pred_valid), .pred_ready(pred_ready),
        .lp_prediction(lp_prediction), .gp_prediction(gp_prediction),
        .choice_prediction(choice_prediction), .global_history(global_history),
        .resolve_valid(resolve_valid), .actually_taken(actually_taken),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_count_up(upd_count_up),
        .upd_count_down(upd_count_down), .upd_taken(upd_taken), .mispredict(mispredict),
        .occupancy(occupancy), .err_underflow(err_underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [HIST_W-1:0] hist;
        bit                lp;
        bit                gp;
        bit                fin;
    } ent_t;

    ent_t              model_q[$];
    logic [HIST_W-1:0] m_ghr;
    bit                m_err;
    bit                e_valid, e_up, e_dn, e_taken, e_mis;
    logic [HIST_W-1:0] e_idx;
    int                n_checks = 0;
    int                n_fail = 0;

    function automatic void model_reset();
        model_q.delete();
        m_ghr = '0; m_err = 0;
        e_valid = 0; e_up = 0; e_dn = 0; e_taken = 0; e_mis = 0; e_idx = '0;
    endfunction

    // Drives one cycle of stimulus, advances the model by the same cycle, and returns at posedge+1.
    task automatic drive_cycle(input bit pv, input bit lp, input bit gp, input bit ch,
                               input bit rv, input bit tk);
        ent_t e;
        bit   fin, ready, do_pop, do_push;
        pred_valid = pv; lp_prediction = lp; gp_prediction = gp; choice_prediction = ch;
        resolve_valid = rv; actually_taken = tk;
        fin     = ch ? gp : lp;
        ready   = (model_q.size() != DEPTH);
        do_pop  = rv && (model_q.size() != 0);
        do_push = pv && ready;
        if (rv && !do_pop) m_err = 1;
        e_valid = do_pop;
        e_mis   = 0;
        if (do_pop) begin
            e       = model_q.pop_front();
            e_idx   = e.hist;
            e_up    = (tk == e.gp) && (tk != e.lp);
            e_dn    = (tk == e.lp) && (tk != e.gp);
            e_taken = tk;
            e_mis   = (e.fin != tk);
`ifdef BRQ_HIST_REPAIR_EN
            if (e_mis) begin
                m_ghr = {e.hist[HIST_W-2:0], tk};
                model_q.delete();
                do_push = 0;
            end
`endif
        end
        if (do_push) begin
            model_q.push_back('{hist: m_ghr, lp: lp, gp: gp, fin: fin});
            m_ghr = {m_ghr[HIST_W-2:0], fin};
        end
        @(posedge clock);
        #1;
        pred_valid = 1'b0; resolve_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [36:0] obs, exp_v;
        apply_reset();
        obs   = {pred_ready, global_history, occupancy, err_underflow, upd_valid, upd_index,
                 upd_count_up, upd_count_down, upd_taken, mispredict};
        exp_v = {1'b1, 12'h000, 4'h0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", obs, exp_v);
        end
        release_reset();
    endtask

    task automatic test_ghr_shift();
        logic [HIST_W-1:0] exp_ghr [3] = '{12'h001, 12'h003, 12'h007};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 0, 1, 1, 0, 0);
            n_checks++;
            if (global_history !== exp_ghr[i]) begin
                n_fail++;
                $display("FAIL ghr_shift[%0d]: got %h expected %h", i, global_history, exp_ghr[i]);
            end
        end
        n_checks++;
        if (occupancy !== 4'd3) begin
            n_fail++;
            $display("FAIL ghr_shift_occ: got %0d expected 3", occupancy);
        end
    endtask

    task automatic test_count_up();
        logic [16:0] obs, exp_v;
        drive_cycle(0, 0, 0, 0, 1, 1);
        obs   = {upd_valid, upd_index, upd_count_up, upd_count_down, upd_taken, mispredict};
        exp_v = {1'b1, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL count_up_packet: got %h expected %h", obs, exp_v);
        end
        drive_cycle(0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({upd_valid, mispredict, occupancy} !== {1'b0, 1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL count_up_pulse: got valid=%b mis=%b occ=%0d expected 0 0 2",
                     upd_valid, mispredict, occupancy);
        end
    endtask

    task automatic test_mispredict();
        logic [HIST_W-1:0] exp_g1, exp_g2;
        logic [OCC_W-1:0]  exp_o1, exp_o2;
`ifdef BRQ_HIST_REPAIR_EN
        exp_g1 = 12'h001; exp_o1 = 4'd0; exp_g2 = 12'h003; exp_o2 = 4'd1;
`else
        exp_g1 = 12'h007; exp_o1 = 4'd3; exp_g2 = 12'h00f; exp_o2 = 4'd4;
`endif
        apply_reset();
        release_reset();
        drive_cycle(1, 1, 0, 1, 0, 0);
        drive_cycle(1, 0, 1, 1, 0, 0);
        drive_cycle(1, 0, 1, 1, 0, 0);
        drive_cycle(1, 0, 1, 1, 1, 1);
        n_checks++;
        if ({upd_valid, upd_index, upd_count_up, upd_count_down, mispredict} !==
            {1'b1, 12'h000, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL mispredict_packet: got v=%b idx=%h up=%b dn=%b mis=%b expected 1 000 0 1 1",
                     upd_valid, upd_index, upd_count_up, upd_count_down, mispredict);
        end
        n_checks++;
        if ({global_history, occupancy} !== {exp_g1, exp_o1}) begin
            n_fail++;
            $display("FAIL mispredict_recover: got ghr=%h occ=%0d expected ghr=%h occ=%0d",
                     global_history, occupancy, exp_g1, exp_o1);
        end
        drive_cycle(1, 0, 1, 1, 0, 0);
        n_checks++;
        if ({global_history, occupancy, mispredict} !== {exp_g2, exp_o2, 1'b0}) begin
            n_fail++;
            $display("FAIL mispredict_next_push: got ghr=%h occ=%0d mis=%b expected ghr=%h occ=%0d mis=0",
                     global_history, occupancy, mispredict, exp_g2, exp_o2);
        end
    endtask

    task automatic test_full();
        logic [HIST_W-1:0] saved;
        apply_reset();
        release_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
        end
        saved = m_ghr;
        n_checks++;
        if ({pred_ready, occupancy, global_history} !== {1'b0, 4'd8, saved}) begin
            n_fail++;
            $display("FAIL full_state: got ready=%b occ=%0d ghr=%h expected 0 8 %h",
                     pred_ready, occupancy, global_history, saved);
        end
        drive_cycle(1, 1, 1, 1, 0, 0);
        n_checks++;
        if ({occupancy, global_history} !== {4'd8, saved}) begin
            n_fail++;
            $display("FAIL full_push_ignored: got occ=%0d ghr=%h expected 8 %h",
                     occupancy, global_history, saved);
        end
        drive_cycle(1, 1, 1, 1, 1, model_q[0].fin);
        n_checks++;
        if ({occupancy, global_history, upd_valid, mispredict, pred_ready} !== {4'd7, saved, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL full_push_pop: got occ=%0d ghr=%h v=%b mis=%b ready=%b expected 7 %h 1 0 1",
                     occupancy, global_history, upd_valid, mispredict, pred_ready, saved);
        end
    endtask

    task automatic test_underflow_and_reset();
        apply_reset();
        release_reset();
        drive_cycle(1, 0, 1, 1, 1, 1);
        n_checks++;
        if ({err_underflow, upd_valid, occupancy, global_history} !== {1'b1, 1'b0, 4'd1, 12'h001}) begin
            n_fail++;
            $display("FAIL underflow_set: got err=%b v=%b occ=%0d ghr=%h expected 1 0 1 001",
                     err_underflow, upd_valid, occupancy, global_history);
        end
        for (int i = 0; i < 4; i++) drive_cycle(1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
        drive_cycle(0, 0, 0, 0, 1, model_q[0].fin);
        n_checks++;
        if ({err_underflow, upd_valid, occupancy} !== {1'b1, 1'b1, 4'd4}) begin
            n_fail++;
            $display("FAIL underflow_sticky: got err=%b v=%b occ=%0d expected 1 1 4",
                     err_underflow, upd_valid, occupancy);
        end
        apply_reset();
        n_checks++;
        if ({occupancy, err_underflow, global_history, upd_valid, pred_ready} !==
            {4'd0, 1'b0, 12'h000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: got occ=%0d err=%b ghr=%h v=%b ready=%b expected 0 0 000 0 1",
                     occupancy, err_underflow, global_history, upd_valid, pred_ready);
        end
        release_reset();
    endtask

    task automatic test_random();
        logic [17:0] obs_s, exp_s;
        logic [16:0] obs_t, exp_t;
        int          pv_pct, rv_pct;
        bit          tk;
        apply_reset();
        release_reset();
        for (int i = 0; i < 3000; i++) begin
            case ((i / 200) % 3)
                0:       begin pv_pct = 90; rv_pct = 20; end
                1:       begin pv_pct = 20; rv_pct = 90; end
                default: begin pv_pct = 60; rv_pct = 60; end
            endcase
            tk = 1'($urandom);
            if (model_q.size() != 0 && $urandom_range(0, 3) != 0) tk = model_q[0].fin;
            drive_cycle($urandom_range(0, 99) < pv_pct, 1'($urandom), 1'($urandom), 1'($urandom),
                        $urandom_range(0, 99) < rv_pct, tk);
            obs_s = {pred_ready, global_history, occupancy, err_underflow};
            exp_s = {model_q.size() != DEPTH, m_ghr, OCC_W'(model_q.size()), m_err};
            n_checks++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL random_state cycle %0d: got %h expected %h", i, obs_s, exp_s);
            end
            if (e_valid) begin
                obs_t = {upd_valid, upd_index, upd_count_up, upd_count_down, upd_taken, mispredict};
                exp_t = {1'b1, e_idx, e_up, e_dn, e_taken, e_mis};
            end else begin
                obs_t = {upd_valid, 15'h0, mispredict};
                exp_t = '0;
            end
            n_checks++;
            if (obs_t !== exp_t) begin
                n_fail++;
                $display("FAIL random_train cycle %0d: got %h expected %h", i, obs_t, exp_t);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        #1;
        test_reset();
        test_ghr_shift();
        test_count_up();
        test_mispredict();
        test_full();
        test_underflow_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue of in-flight conditional-branch predictions for the tournament predictor, placed between the local/global/choice predictors and branch resolution. It owns the speculative global history register, which indexes the choice and global predictors. It records each branch's history index and component predictions at prediction time. At resolution it emits a registered training packet with a correctly aligned index and count-up/count-down decision, and repairs history on a mispredict.

## Interface
Parameters:
- HIST_W, 12, global history width; also the chooser index width.
- DEPTH, 8, maximum in-flight branches; must be a power of two, at least 2.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
- pred_valid  in  1  a conditional branch is predicted this cycle.
- pred_ready  out  1  queue not full (combinational from occupancy only).
- lp_prediction  in  1  local predictor direction.
- gp_prediction  in  1  global predictor direction.
- choice_prediction  in  1  chooser output; 1 selects gp, 0 selects lp.
- global_history  out  HIST_W  speculative GHR, registered.
- resolve_valid  in  1  oldest in-flight branch resolves this cycle (resolution is in order).
- actually_taken  in  1  resolved direction, qualified by resolve_valid.
- upd_valid  out  1  training packet valid (1-cycle pulse).
- upd_index  out  HIST_W  GHR value captured when the branch was pushed.
- upd_count_up  out  1  taken==gp and taken!=lp.
- upd_count_down  out  1  taken==lp and taken!=gp.
- upd_taken  out  1  resolved direction, for global predictor training.
- mispredict  out  1  final prediction differed from the outcome (1-cycle pulse, same cycle as upd_valid).
- occupancy  out  $clog2(DEPTH)+1  current entry count.
- err_underflow  out  1  sticky; set by resolve_valid while empty.

## Operation
- Final prediction: final = choice_prediction ? gp_prediction : lp_prediction.
- Push, on pred_valid && pred_ready:
  - write entry {global_history, lp, gp, final} at the tail;
  - GHR <= {GHR[HIST_W-2:0], final}.
- Pop, on resolve_valid && occupancy!=0:
  - read the head and advance the head pointer;
  - register upd_* from the head entry and actually_taken;
  - upd_count_up and upd_count_down are never both 1; both are 0 when lp==gp.
- Push and pop in the same cycle with no mispredict: both take effect; occupancy is unchanged.
- Mispredict, when a popped entry has final != actually_taken:
  - mispredict pulses;
  - recovery per Configuration.
- pred_ready = (occupancy != DEPTH); a pop in the same cycle does not free a slot early.
- resolve_valid with occupancy 0:
  - no pop and no upd_valid;
  - err_underflow sets; only reset clears it.
  - A push in that same cycle is not visible to the resolve.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is tracked separately.
- pred_valid while not ready: ignored, no state change, GHR held.

## Timing
- Reset values: global_history=0, occupancy=0, pred_ready=1, upd_*=0, mispredict=0, err_underflow=0; pointers 0.
- The GHR shift is visible the cycle after the push, so back-to-back pushes see successive histories.
- Training latency: upd_valid, upd_*, and mispredict appear exactly 1 cycle after the resolving edge.
- Throughput: one push and one pop per cycle.
- Recovery (when enabled) takes effect at the resolving edge:
  - the next cycle shows the repaired GHR and occupancy 0;
  - the next push may occur that cycle.
- Reset asserted mid-operation: all entries are discarded asynchronously, and any pending upd_valid is cleared.

## Configuration
- BRQ_HIST_REPAIR_EN defined:
  - GHR <= {head.hist[HIST_W-2:0], actually_taken};
  - all entries younger than the head are flushed; occupancy becomes 0 and tail = new head;
  - a push in the same cycle is discarded and does not shift the GHR.
- Undefined:
  - no repair and no flush; the GHR keeps speculative bits;
  - a same-cycle push proceeds normally;
  - mispredict still pulses.

## Test plan
- Reset, then push lp=0 gp=1 choice=1 three times -> global_history 0x001, 0x003, 0x007 on successive cycles; occupancy 3.
- Resolve taken=1 for the head (pushed at GHR 0x000, lp=0, gp=1) -> next cycle upd_valid=1, upd_index=0x000, upd_count_up=1, upd_count_down=0, mispredict=0.
- Push lp=1 gp=0 choice=1 at GHR 0x000, then resolve taken=1 -> upd_count_down=1 and mispredict=1.
  - With BRQ_HIST_REPAIR_EN: GHR=0x001 and occupancy=0 the cycle after the resolve.
- Push DEPTH=8 entries with no resolves -> pred_ready=0; a 9th pred_valid is ignored and the GHR is unchanged.
  - A simultaneous push and pop while full -> the pop occurs and the push is dropped.
- resolve_valid while empty -> err_underflow=1 and stays 1, no upd_valid.
  - Then assert reset mid-stream with 4 entries queued -> occupancy=0, err_underflow=0, global_history=0 without a clock edge.
